// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32 width codes, controller
// FSM states and response error codes.
package lsu_pkg;

    // RV32 funct3 width codes
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    // Response error codes
    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_FUNCT3   = 2'b10;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment for the load/store unit (purely combinational).
// Ports:
//   i_addr_lo    byte offset within the word (addr[1:0])
//   i_funct3     RV32 width code
//   i_wen        1 = store, 0 = load
//   i_wdata      right-aligned store data
//   i_rdata      raw memory read word
//   o_wmask      byte write mask for the access width/offset
//   o_wdata      store data shifted into its byte lanes
//   o_rdata      sign/zero-extended load result
//   o_misaligned access not naturally aligned for its width
//   o_illegal    funct3 not usable for this access direction
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_funct3,
    input  logic        i_wen,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_wmask,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata,
    output logic        o_misaligned,
    output logic        o_illegal
);

    logic [4:0]  w_shamt;
    logic [31:0] w_lane;

    assign w_shamt = {i_addr_lo, 3'b000};
    assign w_lane  = i_rdata >> w_shamt;
    assign o_wdata = i_wdata << w_shamt;

    always_comb begin
        o_wmask      = 4'b0000;
        o_rdata      = 32'h0;
        o_misaligned = 1'b0;
        o_illegal    = 1'b0;
        case (i_funct3)
            F3_B: begin
                o_wmask = 4'b0001 << i_addr_lo;
                o_rdata = {{24{w_lane[7]}}, w_lane[7:0]};
            end
            F3_BU: begin
                // unsigned widths exist only for loads
                o_rdata   = {24'h0, w_lane[7:0]};
                o_illegal = i_wen;
            end
            F3_H: begin
                o_wmask      = 4'b0011 << i_addr_lo;
                o_rdata      = {{16{w_lane[15]}}, w_lane[15:0]};
                o_misaligned = i_addr_lo[0];
            end
            F3_HU: begin
                o_rdata      = {16'h0, w_lane[15:0]};
                o_misaligned = i_addr_lo[0];
                o_illegal    = i_wen;
            end
            F3_W: begin
                o_wmask      = 4'b1111;
                o_rdata      = w_lane;
                o_misaligned = |i_addr_lo;
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit controller in front of a combinational data memory.
// Accepts one EXU request at a time, validates it, strobes the memory for
// exactly one cycle after LATENCY wait cycles and returns the result on a
// valid/ready response channel.
// Ports:
//   clock, reset (async, active-low)
//   req_*   EXU request channel (valid/ready, wen, byte addr, wdata, funct3)
//   resp_*  response channel (valid/ready, extended rdata, error code)
//   mem_*   memory data port (strobe, wen, word addresses, lane data, mask,
//           combinational read data)
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int LATENCY = 1
)
(
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_err,
    output logic        mem_valid,
    output logic        mem_wen,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_raddr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic [31:0] mem_rdata
);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_mem_valid;
    logic        r_wen;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [2:0]  r_funct3;
    logic [31:0] r_rdata;
    logic [1:0]  r_err;

    logic        w_idle;
    logic [1:0]  w_addr_lo;
    logic [2:0]  w_funct3;
    logic        w_wen;
    logic [3:0]  w_wmask;
    logic [31:0] w_wdata_sh;
    logic [31:0] w_rdata_ext;
    logic        w_misaligned;
    logic        w_illegal;
    logic [31:0] w_word_addr;

    // In IDLE the aligner checks the incoming request; afterwards it works
    // on the latched copy so the memory port stays stable through ACCESS.
    assign w_idle    = (r_state == S_IDLE);
    assign w_addr_lo = w_idle ? req_addr[1:0] : r_addr[1:0];
    assign w_funct3  = w_idle ? req_funct3    : r_funct3;
    assign w_wen     = w_idle ? req_wen       : r_wen;

    lsu_align u_align (
        .i_addr_lo    (w_addr_lo),
        .i_funct3     (w_funct3),
        .i_wen        (w_wen),
        .i_wdata      (r_wdata),
        .i_rdata      (mem_rdata),
        .o_wmask      (w_wmask),
        .o_wdata      (w_wdata_sh),
        .o_rdata      (w_rdata_ext),
        .o_misaligned (w_misaligned),
        .o_illegal    (w_illegal)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_mem_valid <= 1'b0;
            r_wen       <= 1'b0;
            r_addr      <= 32'h0;
            r_wdata     <= 32'h0;
            r_funct3    <= 3'b000;
            r_rdata     <= 32'h0;
            r_err       <= ERR_NONE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_wen    <= req_wen;
                        r_addr   <= req_addr;
                        r_wdata  <= req_wdata;
                        r_funct3 <= req_funct3;
                        r_rdata  <= 32'h0;
                        if (w_illegal) begin
                            r_err   <= ERR_FUNCT3;
                            r_state <= S_RESP;
                        end else if (w_misaligned) begin
                            r_err   <= ERR_MISALIGN;
                            r_state <= S_RESP;
                        end else begin
                            r_err       <= ERR_NONE;
                            r_cnt       <= 4'(LATENCY);
                            // strobe is pre-registered: it rises for the
                            // cycle in which the counter will read 1
                            r_mem_valid <= (LATENCY == 1);
                            r_state     <= S_ACCESS;
                        end
                    end
                end
                S_ACCESS: begin
                    r_cnt       <= r_cnt - 4'd1;
                    r_mem_valid <= (r_cnt == 4'd2);
                    if (r_cnt == 4'd1) begin
                        if (!r_wen) begin
                            r_rdata <= w_rdata_ext;
                        end
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_word_addr = {r_addr[31:2], 2'b00};

    assign req_ready  = w_idle;
    assign resp_valid = (r_state == S_RESP);
    assign resp_rdata = resp_valid ? r_rdata : 32'h0;
    assign resp_err   = resp_valid ? r_err   : ERR_NONE;

    assign mem_valid  = r_mem_valid;
    assign mem_wen    = r_mem_valid & r_wen;
    assign mem_raddr  = (r_state == S_ACCESS) ? w_word_addr : 32'h0;
    assign mem_waddr  = (r_state == S_ACCESS) ? w_word_addr : 32'h0;
    assign mem_wmask  = mem_wen ? w_wmask    : 4'b0000;
    assign mem_wdata  = mem_wen ? w_wdata_sh : 32'h0;

endmodule
